// File: rtl/dual_issue_dispatch.sv
// dual_issue_dispatch: issue stage in front of the SPU execution core.
// Accepts one program-ordered instruction pair per in_valid/in_ready handshake.
// Each slot goes to the even or odd pipe. The pair is split when:
//   - both slots target the same pipe,
//   - slot1 depends on slot0, or
//   - the countdown scoreboard reports a RAW hazard.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   pair handshake; pair_pc is the address of slot0
//   sN_*                pre-decoded slot fields (N = 0, 1)
//   flush               taken branch: drop the held pair this cycle
//   rf_*, addr_*        registered per-pipe issue fields for register fetch
//   PC, br_first_instr  address of the odd issue; branch-first co-issue flag
//   issue_even/odd      pipe received a real instruction
module dual_issue_dispatch #(
    parameter int REG_ADDR_WIDTH       = 7,
    parameter int INTERNAL_OPCODE_SIZE = 8,
    parameter int UNIT_ID_SIZE         = 3,
    parameter int LAT_W                = 4,
    parameter logic [INTERNAL_OPCODE_SIZE-1:0] NOP_OPCODE = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [31:0]                     pair_pc,
    input  logic                            s0_valid,
    input  logic                            s0_pipe,
    input  logic [UNIT_ID_SIZE-1:0]         s0_unit_id,
    input  logic [INTERNAL_OPCODE_SIZE-1:0] s0_opcode,
    input  logic [REG_ADDR_WIDTH-1:0]       s0_rt,
    input  logic [REG_ADDR_WIDTH-1:0]       s0_ra,
    input  logic [REG_ADDR_WIDTH-1:0]       s0_rb,
    input  logic [REG_ADDR_WIDTH-1:0]       s0_rc,
    input  logic [2:0]                      s0_src_mask,
    input  logic                            s0_wr_en,
    input  logic [LAT_W-1:0]                s0_lat,
    input  logic [17:0]                     s0_imm,
    input  logic                            s1_valid,
    input  logic                            s1_pipe,
    input  logic [UNIT_ID_SIZE-1:0]         s1_unit_id,
    input  logic [INTERNAL_OPCODE_SIZE-1:0] s1_opcode,
    input  logic [REG_ADDR_WIDTH-1:0]       s1_rt,
    input  logic [REG_ADDR_WIDTH-1:0]       s1_ra,
    input  logic [REG_ADDR_WIDTH-1:0]       s1_rb,
    input  logic [REG_ADDR_WIDTH-1:0]       s1_rc,
    input  logic [2:0]                      s1_src_mask,
    input  logic                            s1_wr_en,
    input  logic [LAT_W-1:0]                s1_lat,
    input  logic [17:0]                     s1_imm,
    input  logic                            flush,
    output logic [UNIT_ID_SIZE-1:0]         rf_unit_id,
    output logic [INTERNAL_OPCODE_SIZE-1:0] rf_opcode_even,
    output logic [INTERNAL_OPCODE_SIZE-1:0] rf_opcode_odd,
    output logic [REG_ADDR_WIDTH-1:0]       addr_ra_rd_even,
    output logic [REG_ADDR_WIDTH-1:0]       addr_rb_rd_even,
    output logic [REG_ADDR_WIDTH-1:0]       addr_rc_rd_even,
    output logic [REG_ADDR_WIDTH-1:0]       addr_ra_rd_odd,
    output logic [REG_ADDR_WIDTH-1:0]       addr_rb_rd_odd,
    output logic [REG_ADDR_WIDTH-1:0]       addr_rc_rd_odd,
    output logic [REG_ADDR_WIDTH-1:0]       rf_addr_rt_wt_even,
    output logic [REG_ADDR_WIDTH-1:0]       rf_addr_rt_wt_odd,
    output logic [6:0]                      rf_imm7_even,
    output logic [6:0]                      rf_imm7_odd,
    output logic [9:0]                      rf_imm10_even,
    output logic [9:0]                      rf_imm10_odd,
    output logic [15:0]                     rf_imm16_odd,
    output logic [17:0]                     rf_imm18_odd,
    output logic [31:0]                     PC,
    output logic                            br_first_instr,
    output logic                            issue_even,
    output logic                            issue_odd
);
    localparam int NREG = 1 << REG_ADDR_WIDTH;

    typedef struct packed {
        logic                            pipe;
        logic [UNIT_ID_SIZE-1:0]         unit;
        logic [INTERNAL_OPCODE_SIZE-1:0] op;
        logic [REG_ADDR_WIDTH-1:0]       rt, ra, rb, rc;
        logic [2:0]                      src;   // {ra, rb, rc} read enables
        logic                            wr;
        logic [LAT_W-1:0]                lat;
        logic [17:0]                     imm;
    } slot_t;

    typedef enum logic [1:0] {IDLE, PAIR, SECOND} state_t;

    state_t            state, state_nx;
    slot_t             in0, in1, h0, h1, e_s, o_s;
    logic              h1_vld;
    logic [31:0]       h_pc;
    logic [LAT_W-1:0]  cnt [NREG];
    logic              raw0, raw1, dep, waw, iss0, iss1, e_iss, o_iss, o_idx;

    always_comb begin
        in0 = '{pipe: s0_pipe, unit: s0_unit_id, op: s0_opcode, rt: s0_rt, ra: s0_ra,
                rb: s0_rb, rc: s0_rc, src: s0_src_mask, wr: s0_wr_en, lat: s0_lat, imm: s0_imm};
        in1 = '{pipe: s1_pipe, unit: s1_unit_id, op: s1_opcode, rt: s1_rt, ra: s1_ra,
                rb: s1_rb, rc: s1_rc, src: s1_src_mask, wr: s1_wr_en, lat: s1_lat, imm: s1_imm};
    end

    // Hazard terms for the held pair
    always_comb begin
        raw0 = (h0.src[2] && cnt[h0.ra] != '0) || (h0.src[1] && cnt[h0.rb] != '0) ||
               (h0.src[0] && cnt[h0.rc] != '0);
        raw1 = (h1.src[2] && cnt[h1.ra] != '0) || (h1.src[1] && cnt[h1.rb] != '0) ||
               (h1.src[0] && cnt[h1.rc] != '0);
        dep  = h0.wr && ((h1.src[2] && h1.ra == h0.rt) || (h1.src[1] && h1.rb == h0.rt) ||
                         (h1.src[0] && h1.rc == h0.rt));
        waw  = h0.wr && h1.wr && (h0.rt == h1.rt);
    end

    always_comb begin
        iss0     = 1'b0;
        iss1     = 1'b0;
        in_ready = 1'b0;
        state_nx = state;
        case (state)
            IDLE: in_ready = 1'b1;
            PAIR: begin
                iss0 = !raw0;
                iss1 = iss0 && h1_vld && (h0.pipe != h1.pipe) && !raw1 && !dep && !waw;
                if (iss0) state_nx = (iss1 || !h1_vld) ? IDLE : SECOND;
                in_ready = iss0 && (iss1 || !h1_vld);
            end
            SECOND: begin
                iss1 = !raw1;
                if (iss1) state_nx = IDLE;
                in_ready = iss1;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            iss0     = 1'b0;
            iss1     = 1'b0;
            in_ready = 1'b0;
            state_nx = IDLE;
        end
        if (reset) in_ready = 1'b0;
        // A new pair replaces a fully issued one in the same cycle
        if (in_valid && in_ready)
            state_nx = s0_valid ? PAIR : (s1_valid ? SECOND : IDLE);
    end

    // Steer issued slots onto pipes; co-issue guarantees distinct pipes
    always_comb begin
        e_s   = '0;
        o_s   = '0;
        e_iss = 1'b0;
        o_iss = 1'b0;
        o_idx = 1'b0;
        if (iss0) begin
            if (h0.pipe) begin o_s = h0; o_iss = 1'b1; end
            else         begin e_s = h0; e_iss = 1'b1; end
        end
        if (iss1) begin
            if (h1.pipe) begin o_s = h1; o_iss = 1'b1; o_idx = 1'b1; end
            else         begin e_s = h1; e_iss = 1'b1; end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            h0     <= '0;
            h1     <= '0;
            h1_vld <= 1'b0;
            h_pc   <= '0;
        end else begin
            state <= state_nx;
            if (in_valid && in_ready) begin
                h0     <= in0;
                h1     <= in1;
                h1_vld <= s1_valid;
                h_pc   <= pair_pc;
            end
        end
    end

    // Countdown scoreboard: a load on issue beats the per-cycle decrement
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (reset)
                cnt[i] <= '0;
            else if (iss0 && h0.wr && h0.lat != '0 && h0.rt == REG_ADDR_WIDTH'(i))
                cnt[i] <= h0.lat;
            else if (iss1 && h1.wr && h1.lat != '0 && h1.rt == REG_ADDR_WIDTH'(i))
                cnt[i] <= h1.lat;
            else if (cnt[i] != '0)
                cnt[i] <= cnt[i] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_unit_id         <= '0;
            rf_opcode_even     <= NOP_OPCODE;
            rf_opcode_odd      <= NOP_OPCODE;
            addr_ra_rd_even    <= '0;
            addr_rb_rd_even    <= '0;
            addr_rc_rd_even    <= '0;
            addr_ra_rd_odd     <= '0;
            addr_rb_rd_odd     <= '0;
            addr_rc_rd_odd     <= '0;
            rf_addr_rt_wt_even <= '0;
            rf_addr_rt_wt_odd  <= '0;
            rf_imm7_even       <= '0;
            rf_imm7_odd        <= '0;
            rf_imm10_even      <= '0;
            rf_imm10_odd       <= '0;
            rf_imm16_odd       <= '0;
            rf_imm18_odd       <= '0;
            PC                 <= '0;
            br_first_instr     <= 1'b0;
            issue_even         <= 1'b0;
            issue_odd          <= 1'b0;
        end else begin
            rf_unit_id         <= e_iss ? e_s.unit : o_s.unit;
            rf_opcode_even     <= e_iss ? e_s.op : NOP_OPCODE;
            rf_opcode_odd      <= o_iss ? o_s.op : NOP_OPCODE;
            addr_ra_rd_even    <= e_s.ra;
            addr_rb_rd_even    <= e_s.rb;
            addr_rc_rd_even    <= e_s.rc;
            addr_ra_rd_odd     <= o_s.ra;
            addr_rb_rd_odd     <= o_s.rb;
            addr_rc_rd_odd     <= o_s.rc;
            rf_addr_rt_wt_even <= e_s.rt;
            rf_addr_rt_wt_odd  <= o_s.rt;
            rf_imm7_even       <= e_s.imm[6:0];
            rf_imm7_odd        <= o_s.imm[6:0];
            rf_imm10_even      <= e_s.imm[9:0];
            rf_imm10_odd       <= o_s.imm[9:0];
            rf_imm16_odd       <= o_s.imm[15:0];
            rf_imm18_odd       <= o_s.imm;
            if (o_iss) PC <= h_pc + (o_idx ? 32'd4 : 32'd0);
            br_first_instr     <= o_iss && !o_idx && e_iss;
            issue_even         <= e_iss;
            issue_odd          <= o_iss;
        end
    end
endmodule

// File: tb/tb_dual_issue_dispatch.sv
// tb_dual_issue_dispatch: directed plus randomized stimulus against a
// pending-list / ready-time reference model of the dispatch stage.
module tb_dual_issue_dispatch;
    typedef struct packed {
        bit       pipe;
        bit [2:0] unit;
        bit [7:0] op;
        bit [6:0] rt, ra, rb, rc;
        bit [2:0] src;
        bit       wr;
        bit [3:0] lat;
        bit [17:0] imm;
        bit       idx;
    } ins_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, flush, v0, v1;
    logic [31:0] pair_pc;
    ins_t        a_in, b_in;

    logic        in_ready, br_first_instr, issue_even, issue_odd;
    logic [2:0]  rf_unit_id;
    logic [7:0]  rf_opcode_even, rf_opcode_odd;
    logic [6:0]  ra_e, rb_e, rc_e, ra_o, rb_o, rc_o, rt_e, rt_o;
    logic [6:0]  imm7_e, imm7_o;
    logic [9:0]  imm10_e, imm10_o;
    logic [15:0] imm16_o;
    logic [17:0] imm18_o;
    logic [31:0] PC;

    dual_issue_dispatch dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .pair_pc(pair_pc),
        .s0_valid(v0), .s0_pipe(a_in.pipe), .s0_unit_id(a_in.unit), .s0_opcode(a_in.op),
        .s0_rt(a_in.rt), .s0_ra(a_in.ra), .s0_rb(a_in.rb), .s0_rc(a_in.rc),
        .s0_src_mask(a_in.src), .s0_wr_en(a_in.wr), .s0_lat(a_in.lat), .s0_imm(a_in.imm),
        .s1_valid(v1), .s1_pipe(b_in.pipe), .s1_unit_id(b_in.unit), .s1_opcode(b_in.op),
        .s1_rt(b_in.rt), .s1_ra(b_in.ra), .s1_rb(b_in.rb), .s1_rc(b_in.rc),
        .s1_src_mask(b_in.src), .s1_wr_en(b_in.wr), .s1_lat(b_in.lat), .s1_imm(b_in.imm),
        .flush(flush), .rf_unit_id(rf_unit_id),
        .rf_opcode_even(rf_opcode_even), .rf_opcode_odd(rf_opcode_odd),
        .addr_ra_rd_even(ra_e), .addr_rb_rd_even(rb_e), .addr_rc_rd_even(rc_e),
        .addr_ra_rd_odd(ra_o), .addr_rb_rd_odd(rb_o), .addr_rc_rd_odd(rc_o),
        .rf_addr_rt_wt_even(rt_e), .rf_addr_rt_wt_odd(rt_o),
        .rf_imm7_even(imm7_e), .rf_imm7_odd(imm7_o), .rf_imm10_even(imm10_e),
        .rf_imm10_odd(imm10_o), .rf_imm16_odd(imm16_o), .rf_imm18_odd(imm18_o),
        .PC(PC), .br_first_instr(br_first_instr), .issue_even(issue_even), .issue_odd(issue_odd)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: in-order list of unissued slots; each register
    // remembers the first cycle at which a reader may issue.
    ins_t        q[$];
    int          ready_at [128];
    int          cyc = 0;
    logic [31:0] base_pc = '0;
    logic [31:0] exp_pc = '0;

    function automatic bit m_raw(ins_t i);
        return (i.src[2] && cyc < ready_at[i.ra]) || (i.src[1] && cyc < ready_at[i.rb]) ||
               (i.src[0] && cyc < ready_at[i.rc]);
    endfunction

    function automatic bit reads(ins_t i, bit [6:0] r);
        return (i.src[2] && i.ra == r) || (i.src[1] && i.rb == r) || (i.src[0] && i.rc == r);
    endfunction

    task automatic step();
        ins_t ev, od, t;
        bit   ie, io, ih, i2, rdy;
        int   n;
        #1;
        ev = '0; od = '0; ie = 0; io = 0; ih = 0; i2 = 0;
        n = q.size();
        if (!reset && !flush && n > 0) begin
            ih = !m_raw(q[0]);
            if (n == 2 && ih)
                i2 = (q[0].pipe != q[1].pipe) && !m_raw(q[1]) &&
                     !(q[0].wr && reads(q[1], q[0].rt)) &&
                     !(q[0].wr && q[1].wr && q[0].rt == q[1].rt);
        end
        rdy = !reset && !flush && (n == 0 || (ih && (n == 1 || i2)));
        if (ih) begin if (q[0].pipe) begin od = q[0]; io = 1; end else begin ev = q[0]; ie = 1; end end
        if (i2) begin if (q[1].pipe) begin od = q[1]; io = 1; end else begin ev = q[1]; ie = 1; end end
        chk("in_ready", in_ready, rdy);
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            foreach (ready_at[k]) ready_at[k] = 0;
            exp_pc = '0;
        end else begin
            if (io) exp_pc = base_pc + (od.idx ? 32'd4 : 32'd0);
            if (ih && q[0].wr && q[0].lat != 0) ready_at[q[0].rt] = cyc + int'(q[0].lat) + 1;
            if (i2 && q[1].wr && q[1].lat != 0) ready_at[q[1].rt] = cyc + int'(q[1].lat) + 1;
            if (flush) q.delete();
            else begin
                if (ih) void'(q.pop_front());
                if (i2) void'(q.pop_front());
            end
            if (in_valid && rdy) begin
                base_pc = pair_pc;
                if (v0) begin t = a_in; t.idx = 0; q.push_back(t); end
                if (v1) begin t = b_in; t.idx = 1; q.push_back(t); end
            end
        end
        chk("issue_even", issue_even, ie);
        chk("issue_odd", issue_odd, io);
        chk("op_even", rf_opcode_even, ie ? ev.op : 8'h0);
        chk("op_odd", rf_opcode_odd, io ? od.op : 8'h0);
        chk("unit", rf_unit_id, ie ? ev.unit : (io ? od.unit : 3'd0));
        chk("addr_even", {ra_e, rb_e, rc_e, rt_e}, {ev.ra, ev.rb, ev.rc, ev.rt});
        chk("addr_odd", {ra_o, rb_o, rc_o, rt_o}, {od.ra, od.rb, od.rc, od.rt});
        chk("imm_even", {imm10_e, imm7_e}, {ev.imm[9:0], ev.imm[6:0]});
        chk("imm_odd", {imm18_o, imm16_o, imm10_o, imm7_o},
            {od.imm, od.imm[15:0], od.imm[9:0], od.imm[6:0]});
        chk("pc", PC, exp_pc);
        chk("br_first", br_first_instr, io && ie && !od.idx && ev.idx);
        cyc++;
        @(negedge clk);
    endtask

    function automatic ins_t mk(bit p, bit [7:0] op, bit [6:0] rt, bit [6:0] ra,
                                bit [2:0] src, bit wr, bit [3:0] lat);
        ins_t i;
        i.pipe = p; i.unit = op[2:0]; i.op = op; i.rt = rt; i.ra = ra;
        i.rb = ra + 7'd1; i.rc = ra + 7'd2; i.src = src; i.wr = wr; i.lat = lat;
        i.imm = {op, 10'h155}; i.idx = 0;
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        i.pipe = 1'($urandom_range(0, 1));
        i.unit = 3'($urandom_range(0, 7));
        i.op   = 8'($urandom_range(1, 255));
        i.rt   = 7'($urandom_range(0, 7));
        i.ra   = 7'($urandom_range(0, 7));
        i.rb   = 7'($urandom_range(0, 7));
        i.rc   = 7'($urandom_range(0, 7));
        i.src  = 3'($urandom_range(0, 7));
        i.wr   = ($urandom_range(0, 3) != 0);
        i.lat  = 4'($urandom_range(0, 7));
        i.imm  = 18'($urandom_range(0, 262143));
        i.idx  = 0;
        return i;
    endfunction

    task automatic drv(input bit v, input bit [31:0] pc, input bit sv0, input ins_t a,
                       input bit sv1, input ins_t b, input bit fl);
        in_valid = v; pair_pc = pc; v0 = sv0; a_in = a; v1 = sv1; b_in = b; flush = fl;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drv(0, 0, 0, '0, 0, '0, 0);
            step();
        end
    endtask

    initial begin
        foreach (ready_at[k]) ready_at[k] = 0;
        reset = 1;
        drv(0, 0, 0, '0, 0, '0, 0);
        step();
        step();
        reset = 0;
        idle(1);
        // independent even add + odd load
        drv(1, 32'h100, 1, mk(0, 8'h11, 3, 1, 3'b110, 1, 2), 1, mk(1, 8'h22, 4, 10, 3'b100, 1, 0), 0);
        step();
        idle(2);
        // both slots on the even pipe
        drv(1, 32'h140, 1, mk(0, 8'h12, 6, 1, 3'b100, 1, 0), 1, mk(0, 8'h13, 7, 2, 3'b100, 1, 0), 0);
        step();
        idle(3);
        // slot1 reads slot0's rt with lat 6
        drv(1, 32'h180, 1, mk(0, 8'h14, 5, 1, 3'b100, 1, 6), 1, mk(1, 8'h23, 8, 5, 3'b100, 1, 0), 0);
        step();
        idle(10);
        // odd branch first, independent even second
        drv(1, 32'h200, 1, mk(1, 8'h30, 0, 2, 3'b100, 0, 0), 1, mk(0, 8'h15, 11, 3, 3'b100, 1, 1), 0);
        step();
        idle(2);
        // flush a pair stalled in PAIR on r20
        drv(1, 32'h240, 1, mk(0, 8'h16, 20, 1, 3'b100, 1, 7), 0, '0, 0);
        step();
        drv(1, 32'h280, 1, mk(0, 8'h17, 21, 20, 3'b100, 1, 0), 1, mk(1, 8'h24, 22, 1, 3'b100, 1, 0), 0);
        step();
        idle(1);
        drv(0, 0, 0, '0, 0, '0, 1);
        step();
        idle(10);
        // reset while slot1 waits in SECOND on r9
        drv(1, 32'h300, 1, mk(0, 8'h18, 9, 1, 3'b100, 1, 3), 1, mk(0, 8'h19, 12, 9, 3'b100, 1, 0), 0);
        step();
        idle(2);
        reset = 1;
        idle(1);
        reset = 0;
        drv(1, 32'h340, 1, mk(0, 8'h1a, 13, 9, 3'b100, 1, 0), 0, '0, 0);
        step();
        idle(2);
        // random traffic
        for (int k = 0; k < 2000; k++) begin
            drv($urandom_range(0, 3) != 0, 32'($urandom_range(0, 65535)) << 3,
                $urandom_range(0, 5) != 0, rnd_ins(), $urandom_range(0, 5) != 0, rnd_ins(),
                $urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 0;
        idle(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dual_issue_dispatch.md
Name: dual_issue_dispatch

Overview:
- Issue stage that feeds the SPU execution core. Accepts one pre-decoded, program-ordered instruction pair per handshake.
- Routes each slot to the even or odd pipe, splitting the pair on structural hazards and intra-pair dependences.
- A per-register countdown scoreboard holds RAW-dependent instructions back.
- Drives the registered rf_* issue fields and PC/br_first_instr consumed by the register-fetch stage.

Parameters:
REG_ADDR_WIDTH, 7, register address width (128 registers)
INTERNAL_OPCODE_SIZE, 8, internal opcode width
UNIT_ID_SIZE, 3, execution unit id width
LAT_W, 4, scoreboard counter width
NOP_OPCODE, 0, opcode driven on a pipe with no issue

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  pair valid
in_ready  out  1  pair accepted when in_valid&in_ready at posedge
pair_pc  in  32  address of slot0; slot1 = pair_pc+4
sN_valid (N=0,1)  in  1  slot holds an instruction
sN_pipe  in  1  0=even, 1=odd
sN_unit_id  in  UNIT_ID_SIZE  execution unit
sN_opcode  in  INTERNAL_OPCODE_SIZE  internal opcode
sN_rt, sN_ra, sN_rb, sN_rc  in  REG_ADDR_WIDTH each  dest/source addresses
sN_src_mask  in  3  read enables {ra,rb,rc}
sN_wr_en  in  1  writes rt
sN_lat  in  LAT_W  stall cycles before a dependent may issue
sN_imm  in  18  immediate
flush  in  1  branch taken: drop held pair
rf_unit_id  out  UNIT_ID_SIZE  even issue's unit if any, else odd's
rf_opcode_even, rf_opcode_odd  out  INTERNAL_OPCODE_SIZE
addr_ra/rb/rc_rd_even, addr_ra/rb/rc_rd_odd  out  REG_ADDR_WIDTH
rf_addr_rt_wt_even, rf_addr_rt_wt_odd  out  REG_ADDR_WIDTH
rf_imm7_even/odd, rf_imm10_even/odd, rf_imm16_odd, rf_imm18_odd  out  7/10/16/18  low bits of the issued slot's imm
PC  out  32  address of the odd-issued instruction
br_first_instr  out  1  odd issue is slot0 and an even slot1 issues the same cycle
issue_even, issue_odd  out  1  pipe received a real instruction

Behaviour:
- Reset: state IDLE; all scoreboard counters 0; all outputs 0; opcodes NOP_OPCODE; in_ready 0 during reset.
- FSM:
  - IDLE: in_ready=1. On accept, latch the pair; a slot with sN_valid=0 counts as already issued. Go to PAIR, or stay IDLE if neither slot is valid.
  - PAIR: slot0 pending.
  - SECOND: only slot1 pending.
- Issue timing: earliest issue is the cycle after accept. Outputs are registered, so they are visible after the issuing edge.
- in_ready is also 1 in the cycle all remaining slots issue. This allows back-to-back pairs without a bubble. in_ready does not depend on in_valid.
- RAW on a source: its src_mask bit is set and counter[addr] != 0.
- PAIR cycle:
  - slot0 issues if it has no RAW.
  - slot1 co-issues only if all hold: slot0 issues; pipes differ; slot1 has no RAW; slot1 reads none of slot0's rt (when s0_wr_en); both-write with equal rt is excluded.
  - If both issue → IDLE. If only slot0 issues → SECOND (or IDLE if slot1 is invalid). If slot0 does not issue → stay in PAIR.
  - slot1 never issues before slot0.
- SECOND: slot1 issues if it has no RAW → IDLE.
- Per-pipe outputs:
  - Pipe with no issue: opcode NOP_OPCODE, addresses 0, issue_x 0.
  - issue_x=1 on the cycle its fields are presented.
- Scoreboard:
  - On issue with wr_en and lat>0, counter[rt] <= lat. Otherwise every nonzero counter decrements by 1 per cycle.
  - A load wins over a decrement on the same register.
  - Effect: a dependent issues no earlier than t+lat+1. lat=0 allows back-to-back issue.
- flush:
  - Has priority over issue in the same cycle: no issue, held pair discarded, state IDLE, in_ready=0 that cycle.
  - Scoreboard keeps counting.
- PC = pair_pc + 4*slot index of the odd issue. PC is held when there is no odd issue.

Test Plan:
- After reset: rf_opcode_even=rf_opcode_odd=0, issue_even=issue_odd=0, in_ready=1.
- Independent pair (slot0 even add rt=3, slot1 odd lqd rt=4), pair_pc=0x100, accepted cycle 0 → both issue cycle 1; PC=0x104; br_first_instr=0; in_ready=1 in cycle 1.
- Both slots even → slot0 issues cycle 1, slot1 cycle 2, issue_odd=0 both cycles.
- slot0 even rt=5, lat=6; slot1 odd reads ra=5 → slot0 issues cycle 1; slot1 issue_odd first in cycle 8; in_ready=0 for cycles 2-7.
- slot0 odd branch, slot1 even independent → co-issue, br_first_instr=1, PC=pair_pc. flush with pair pending in PAIR state → no issue, IDLE next cycle.
- reset asserted while in SECOND with counter[9]=3 → state IDLE, counter 0, outputs NOP; a reader of r9 then issues the cycle after accept.
